// File: rtl/reg_arb_pkg.sv
// rtl/reg_arb_pkg.sv - shared state type and constants for reg_write_arbiter
package reg_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  localparam int DATA_W    = 8;
  localparam int BURST_MAX = 8;

endpackage

// File: rtl/reg_write_arbiter_if.sv
// rtl/reg_write_arbiter_if.sv - requester/register-bank bus of reg_write_arbiter (LOCK only under REG_ARB_BURST_EN)
interface reg_write_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int N_REG = 4
);
  import reg_arb_pkg::*;

  localparam int AW = $clog2(N_REG);

  logic [N_REQ-1:0]        REQ;
  logic [N_REQ*AW-1:0]     ADDR;
  logic [N_REQ*DATA_W-1:0] WDATA;
`ifdef REG_ARB_BURST_EN
  logic [N_REQ-1:0]        LOCK;
`endif
  logic [N_REQ-1:0]        ACK;
  logic [N_REG-1:0]        REG_EN;
  logic [DATA_W-1:0]       REG_IN;
  logic                    BUSY;

  // Requester / testbench side.
  modport master (
`ifdef REG_ARB_BURST_EN
    output LOCK,
`endif
    output REQ, ADDR, WDATA,
    input  ACK, REG_EN, REG_IN, BUSY
  );

  // Arbiter side.
  modport slave (
`ifdef REG_ARB_BURST_EN
    input  LOCK,
`endif
    input  REQ, ADDR, WDATA,
    output ACK, REG_EN, REG_IN, BUSY
  );

endinterface

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin winner selection starting at ptr
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] winner,
  output logic          valid
);

  int            idx;
  logic [IW-1:0] idx_l;

  // Scan ptr, ptr+1, ... with wrap; the first active request wins.
  always_comb begin
    winner = ptr;
    valid  = 1'b0;
    idx    = 0;
    idx_l  = '0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      idx_l = IW'(idx);
      if (!valid && req[idx_l]) begin
        valid  = 1'b1;
        winner = idx_l;
      end
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// rtl/reg_write_arbiter.sv - round-robin write arbiter for a shared register bank (burst option: REG_ARB_BURST_EN)
module reg_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int N_REG = 4
) (
  input logic               CLK,
  input logic               RST,
  reg_write_arbiter_if.slave bus
);

  localparam int AW = $clog2(N_REG);
  localparam int IW = $clog2(N_REQ);

  arb_state_t        state, state_next;
  logic [IW-1:0]     ptr, ptr_next;
  logic [IW-1:0]     win, win_next;
  logic [AW-1:0]     lat_addr, addr_next;
  logic [DATA_W-1:0] reg_in_next;
  logic [N_REQ-1:0]  ack_next;
  logic [N_REG-1:0]  en_next;
  logic              busy_next;

  logic [IW-1:0]     pick_idx;
  logic              pick_valid;
  logic [IW-1:0]     sel;
  logic [AW-1:0]     sel_addr;
  logic [DATA_W-1:0] sel_data;

`ifdef REG_ARB_BURST_EN
  localparam int CW = $clog2(BURST_MAX);
  logic [CW-1:0]     burst_cnt, cnt_next;
  logic              sel_lock;
`endif

  rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
    .req    (bus.REQ),
    .ptr    (ptr),
    .winner (pick_idx),
    .valid  (pick_valid)
  );

  // In DONE the held winner is re-read (burst re-latch); otherwise the fresh pick.
  assign sel = (state == DONE) ? win : pick_idx;

  // Extract the selected requester's address, data and lock bit.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
`ifdef REG_ARB_BURST_EN
    sel_lock = 1'b0;
`endif
    for (int i = 0; i < N_REQ; i++) begin
      if (sel == IW'(i)) begin
        sel_addr = bus.ADDR[i*AW +: AW];
        sel_data = bus.WDATA[i*DATA_W +: DATA_W];
`ifdef REG_ARB_BURST_EN
        sel_lock = bus.LOCK[i];
`endif
      end
    end
  end

  // Next-state and next-output logic; outputs are registered from these values.
  always_comb begin
    state_next  = state;
    ptr_next    = ptr;
    win_next    = win;
    addr_next   = lat_addr;
    reg_in_next = bus.REG_IN;
    ack_next    = '0;
    en_next     = '0;
`ifdef REG_ARB_BURST_EN
    cnt_next    = burst_cnt;
`endif
    unique case (state)
      IDLE: begin
        if (pick_valid) begin
          win_next    = pick_idx;
          addr_next   = sel_addr;
          reg_in_next = sel_data;
          state_next  = GRANT;
        end
      end
      GRANT: begin
        // Out-of-range addresses match no bit, so no enable fires.
        for (int r = 0; r < N_REG; r++) begin
          if (lat_addr == AW'(r)) en_next[r] = 1'b1;
        end
        state_next = WRITE;
      end
      WRITE: begin
        for (int i = 0; i < N_REQ; i++) begin
          if (win == IW'(i)) ack_next[i] = 1'b1;
        end
        state_next = DONE;
      end
      DONE: begin
        ptr_next   = (int'(win) == N_REQ - 1) ? IW'(0) : win + 1'b1;
        state_next = IDLE;
`ifdef REG_ARB_BURST_EN
        cnt_next = '0;
        if (sel_lock && (int'(burst_cnt) < BURST_MAX - 1)) begin
          ptr_next    = ptr;
          addr_next   = sel_addr;
          reg_in_next = sel_data;
          cnt_next    = burst_cnt + 1'b1;
          state_next  = GRANT;
        end
`endif
      end
      default: state_next = IDLE;
    endcase
    busy_next = (state_next != IDLE);
  end

  // State, latched transaction and registered outputs; reset drops any transaction in flight.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      ptr        <= '0;
      win        <= '0;
      lat_addr   <= '0;
      bus.ACK    <= '0;
      bus.REG_EN <= '0;
      bus.REG_IN <= '0;
      bus.BUSY   <= 1'b0;
`ifdef REG_ARB_BURST_EN
      burst_cnt  <= '0;
`endif
    end else begin
      state      <= state_next;
      ptr        <= ptr_next;
      win        <= win_next;
      lat_addr   <= addr_next;
      bus.ACK    <= ack_next;
      bus.REG_EN <= en_next;
      bus.REG_IN <= reg_in_next;
      bus.BUSY   <= busy_next;
`ifdef REG_ARB_BURST_EN
      burst_cnt  <= cnt_next;
`endif
    end
  end

endmodule

// File: doc/reg_write_arbiter.md
# reg_write_arbiter

Round-robin write arbiter that shares a bank of N_REG 8-bit enable-gated storage registers between N_REQ independent requesters. Each requester holds a request with address and data; the arbiter picks one winner, drives that register's load enable and data for exactly one cycle, then acknowledges the winner. The block sits between the control/sequencing logic and the datapath register bank, and is the only agent allowed to drive the bank's enables.

## Interface
Parameters:
- N_REQ, 4, number of requesters (2..8)
- N_REG, 4, number of 8-bit registers in the bank (2..16); AW = $clog2(N_REG)

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  reset, asynchronous, active-high
- REQ  in  N_REQ  per-requester write request, level, held until ACK
- ADDR  in  N_REQ*AW  target register index, requester i at [i*AW +: AW]
- WDATA  in  N_REQ*8  write data, requester i at [i*8 +: 8]
- ACK  out  N_REQ  one-hot, one-cycle pulse: requester's write has been committed
- REG_EN  out  N_REG  one-hot load enable to the register bank
- REG_IN  out  8  shared write data bus to the register bank
- BUSY  out  1  high whenever the FSM is not in IDLE

## Operation
- FSM states: IDLE, GRANT, WRITE, DONE.
- IDLE: if any REQ is high, select the winner by round-robin starting at PTR, latch the winner index, ADDR and WDATA, and go to GRANT. Otherwise stay in IDLE.
- GRANT: drive REG_IN with the latched data. REG_EN stays 0 (bus setup cycle). Go to WRITE.
- WRITE: REG_EN[latched addr] = 1 for this cycle only, and REG_IN keeps its value. Go to DONE.
- DONE: ACK[winner] = 1 for this cycle only. PTR <= winner+1, wrapping modulo N_REQ. Go to IDLE.
- Round-robin: the requester at PTR has highest priority, then PTR+1, and so on, wrapping. PTR resets to 0.
- Address out of range (ADDR >= N_REG): no REG_EN bit is asserted in WRITE, but ACK is still issued. The transaction is otherwise normal.
- A requester dropping REQ before ACK has no effect. Data and address were latched in IDLE, so the write completes.
- A requester must deassert REQ in the cycle after ACK. If REQ is still high in IDLE, it is treated as a new request.
- Reset mid-transaction: the FSM returns to IDLE, the latched transaction is discarded, and no ACK and no REG_EN are issued.

## Timing
- Reset values: ACK = 0, REG_EN = 0, REG_IN = 8'h00, BUSY = 0, FSM = IDLE, PTR = 0.
- All outputs are registered.
- Latency from REQ high in IDLE (cycle 0) is fixed:
  - BUSY = 1 from cycle 1.
  - REG_IN is valid from cycle 1.
  - REG_EN pulses in cycle 2.
  - ACK pulses in cycle 3.
  - FSM is back in IDLE in cycle 4.
- Throughput: one write per 4 cycles.
- Register contents are updated at the edge that ends cycle 2, so they are visible from cycle 3, in the same cycle as ACK.
- Simultaneous requests: exactly one winner per IDLE evaluation. Losers keep REQ high and are evaluated again at the next IDLE.

## Configuration
- Macro REG_ARB_BURST_EN.
- Defined: adds input LOCK (N_REQ bits).
  - If the winner's LOCK bit is high in DONE, PTR is not advanced and the FSM goes DONE -> GRANT directly. The same requester's current ADDR and WDATA are re-latched in DONE.
  - Burst throughput is one write per 3 cycles.
  - A burst is capped at 8 consecutive writes; after the 8th, PTR advances regardless of LOCK.
- Undefined: no LOCK port, and behaviour is exactly as described above.

## Structure
- Shared package reg_arb_pkg holds:
  - the state enum type arb_state_t (IDLE, GRANT, WRITE, DONE)
  - the data width constant DATA_W = 8
  - the burst cap constant BURST_MAX = 8
- One sub-module: rr_pick. It is combinational; inputs are the request vector and PTR, and outputs are the winner index and a valid flag. It is instantiated once.

## Test plan
- Single request, N_REQ=4, N_REG=4:
  - Stimulus: REQ=0001, ADDR0=2, WDATA0=8'hA5.
  - Required: REG_EN=0100 in cycle 2, REG_IN=8'hA5, ACK=0001 in cycle 3, BUSY high for cycles 1-3.
- Contention:
  - Stimulus: REQ=1111 held (each requester drops REQ after its own ACK), PTR=0.
  - Required: ACK order is 0,1,2,3, with ACKs 4 cycles apart; PTR ends at 0.
- Fairness after wrap:
  - Stimulus: requester 3 wins, then REQ=1001.
  - Required: requester 0 is granted next, not requester 3.
- Out of range:
  - Stimulus: N_REG=4, ADDR=3 (valid), then a parameter variant with N_REG=3 and ADDR=3.
  - Required: in the second case REG_EN stays 000 throughout and ACK still pulses.
- Reset mid-operation:
  - Stimulus: assert RST in the WRITE cycle.
  - Required: REG_EN and ACK drop to 0 immediately, and no ACK appears after RST is released.
- Burst (REG_ARB_BURST_EN):
  - Stimulus: LOCK[1]=1, REQ=0011.
  - Required: requester 1 receives 8 ACKs 3 cycles apart, then requester 0 is granted.
